// File: rtl/mproc_param_pkg.sv
// mproc_param_pkg: shared FSM encoding, instruction class/op codes and field layout for mproc_param.
package mproc_param_pkg;

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_EXEC  = 3'd1;
   localparam logic [2:0] S_LDIMM = 3'd2;
   localparam logic [2:0] S_STORE = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [4:0] CLS_ALU  = 5'b00000;
   localparam logic [4:0] CLS_HALT = 5'b00001;
   localparam logic [1:0] PFX_JC   = 2'b01;
   localparam logic [1:0] PFX_LDI  = 2'b10;
   localparam logic [1:0] PFX_ST   = 2'b11;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef struct packed {
      logic [4:0] cls;
      logic [1:0] op;
      logic [2:0] d;
      logic [2:0] b;
      logic [2:0] a;
   } instr_t;

endpackage

// File: rtl/mproc_param_regfile.sv
// regfile_param: 8 x DW register file, two asynchronous read ports, one synchronous write port.
module regfile_param #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [2:0]    wa,
   input  logic [DW-1:0] wd,
   input  logic [2:0]    ra_a,
   input  logic [2:0]    ra_b,
   output logic [DW-1:0] rd_a,
   output logic [DW-1:0] rd_b
);

   logic [DW-1:0] regs [8];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rd_a = regs[ra_a];
   assign rd_b = regs[ra_b];

endmodule

// File: rtl/mproc_param.sv
// mproc_param: multi-cycle 8-register processor with held-until-accepted memory handshake.
module mproc_param
   import mproc_param_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] d_in,
   input  logic          mem_rdy,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] d_out,
   output logic          rd_req,
   output logic          wr_req,
   output logic          halted
);

   logic [2:0]    state;
   logic [2:0]    exec_next;
   logic [AW-1:0] pc;
   logic [15:0]   ir;
   instr_t        f;
   logic          c;
   logic [DW-1:0] ra;
   logic [DW-1:0] rb;
   logic [DW-1:0] alu_y;
   logic [DW-1:0] wd;
   logic [DW:0]   sum;
   logic          sub;
   logic          is_alu;
   logic          we;

   assign f      = instr_t'(ir);
   assign is_alu = f.cls == CLS_ALU;
   assign sub    = f.op == OP_SUB;

   // SUB is r[a] + ~r[b] + 1, so its carry-out is the "no borrow" flag
   assign sum   = {1'b0, ra} + {1'b0, sub ? ~rb : rb} + (DW+1)'(sub);
   assign alu_y = f.op == OP_AND ? ra & rb : f.op == OP_XOR ? ra ^ rb : sum[DW-1:0];

   assign rd_req = state == S_FETCH || state == S_LDIMM;
   assign wr_req = state == S_STORE;
   assign halted = state == S_HALT;
   assign addr   = wr_req ? rb[AW-1:0] : pc;
   assign d_out  = ra;

   assign we = (state == S_EXEC && is_alu) || (state == S_LDIMM && mem_rdy);
   assign wd = state == S_LDIMM ? d_in : alu_y;

   assign exec_next = is_alu                ? S_FETCH :
                      f.cls == CLS_HALT     ? S_HALT  :
                      ir[15:14] == PFX_LDI  ? S_LDIMM :
                      ir[15:14] == PFX_ST   ? S_STORE : S_FETCH;

   regfile_param #(.DW(DW)) u_rf (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .wa   (f.d),
      .wd   (wd),
      .ra_a (f.a),
      .ra_b (f.b),
      .rd_a (ra),
      .rd_b (rb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= '0;
         ir    <= '0;
         c     <= 1'b0;
      end else begin
         case (state)
            S_FETCH: if (mem_rdy) begin
               ir    <= d_in[15:0];
               pc    <= pc + AW'(1);
               state <= S_EXEC;
            end
            S_EXEC: begin
               state <= exec_next;
               if (is_alu && (f.op == OP_ADD || sub)) c <= sum[DW];
               if (ir[15:14] == PFX_JC && c) pc <= AW'(ir[7:0]);
            end
            S_LDIMM: if (mem_rdy) begin
               pc    <= pc + AW'(1);
               state <= S_FETCH;
            end
            S_STORE: if (mem_rdy) state <= S_FETCH;
            default: ;
         endcase
      end
   end

endmodule
